tpu_host_loader: RTL and testbench
==================================

Name: tpu_host_loader

Overview:
Byte-stream command front end that sits directly upstream of tpu_top and drives its load/start interface. It parses host commands arriving on an 8-bit valid/ready stream and writes weights and activations into tpu_top. It then pulses start, waits for done, and streams the four result words back out on an 8-bit valid/ready stream. It is the bridge between a UART/host link and the systolic core.

Parameters:
SIZE, 4, systolic array dimension; largest legal matrix_size
DATA_WIDTH, 8, width of load_data (fixed at 8 for the byte protocol)
ACC_WIDTH, 32, width of each result word; must be a multiple of 8
DONE_TIMEOUT, 4096, cycles to wait for tpu_done before aborting

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  command/data byte from host
rx_valid  in  1  rx_data valid
rx_ready  out  1  block accepts rx byte this cycle
tx_data  out  8  response byte to host
tx_valid  out  1  tx_data valid
tx_ready  in  1  host accepts tx byte
load_weight  out  1  to tpu_top
load_activation  out  1  to tpu_top
load_addr  out  8  to tpu_top
load_data  out  DATA_WIDTH  to tpu_top
start  out  1  one-cycle start pulse to tpu_top
matrix_size  out  8  registered size to tpu_top, held between runs
busy  in  1  from tpu_top (status only)
done  in  1  from tpu_top
result_0..result_3  in  ACC_WIDTH each  from tpu_top
err  out  3  sticky errors: [0] bad opcode, [1] timeout, [2] bad size

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: rx_ready, tx_valid, tx_data, load_*, start, matrix_size, err. Reset mid-operation abandons any load or transfer with no partial output afterwards.
- An rx byte is accepted on the clk edge where rx_valid && rx_ready. A tx byte is consumed on the edge where tx_valid && tx_ready. tx_data must stay stable while tx_valid && !tx_ready.
- rx_ready=1 in IDLE, GET_LEN, LOAD and GET_SIZE. rx_ready=0 in all other states.
- Opcodes (accepted in IDLE):
  - 0x57 'W' -> GET_LEN, target=weight.
  - 0x41 'A' -> GET_LEN, target=activation.
  - 0x53 'S' -> GET_SIZE.
  - 0x43 'C' -> clear err, stay IDLE.
  - Any other byte -> set err[0], stay IDLE, byte dropped.
- GET_LEN: accepted byte N. N=0 -> IDLE with no loads. Otherwise idx=0 -> LOAD.
- LOAD: each accepted byte b produces, on the following cycle only, load_weight or load_activation =1 (per target), load_addr=idx, load_data=b. idx increments. After the Nth byte -> IDLE. With rx_valid held high this gives back-to-back single-cycle writes.
  - When no byte is accepted, load_* strobes are 0; load_addr/load_data hold their last value.
- GET_SIZE: accepted byte s.
  - s==0 or s>SIZE: set err[2], queue the single byte 0xEE -> SEND.
  - Otherwise: matrix_size<=s -> START.
- START: start=1 for exactly one cycle, the cycle after the size byte is accepted. Timeout counter cleared. -> WAIT_DONE.
- WAIT_DONE: count cycles.
  - done=1: capture result_0..3 into a shift register that same edge -> SEND with 4*ACC_WIDTH/8 bytes. done takes priority over timeout on the same cycle.
  - Counter reaches DONE_TIMEOUT: set err[1], queue 0xEE -> SEND.
- SEND: tx_valid=1 from the cycle after entry. Bytes go out result_0 first, each word least-significant byte first. After the last byte handshakes, tx_valid=0 the next cycle -> IDLE.
- Error bits are sticky until 'C' or reset. Errors never block later commands.
- Commands arriving during START/WAIT_DONE/SEND are back-pressured via rx_ready=0, never dropped.

Test Plan:
- W,4,5,7,6,8 then A,4,1,2,3,4 with rx_valid held high -> 4 consecutive load_weight cycles, addr 0..3, data 5,7,6,8; then 4 load_activation cycles, data 1,2,3,4; no gaps, strobes single-cycle.
- Above, then S,2 with real tpu_top -> start pulse one cycle after the size byte, matrix_size=2; after done, tx bytes 19,0,0,0,22,0,0,0,43,0,0,0,50,0,0,0.
- Identity case: W 1,0,0,1; A 5,6,7,8; S,2 -> tx words 5,6,7,8. tx_ready toggled 50% -> tx_data stable while stalled, no byte lost or duplicated.
- Byte 0x99 in IDLE -> err=3'b001, no strobes. S,0 -> err=3'b101, tx single byte 0xEE, start never asserted. C -> err=0.
- S,2 with done tied 0 -> after DONE_TIMEOUT cycles err[1]=1, tx single byte 0xEE, return to IDLE and accept the next W.
- rst_n pulled low during LOAD (after 2 of 4 bytes) and separately during SEND -> all outputs 0 immediately. After release, a fresh W,1,9 yields one load_weight at addr 0, data 9.

Source files
------------

// File: rtl/tpu_host_loader.sv
// tpu_host_loader: byte-stream command front end for tpu_top.
// Parses host commands on an 8-bit valid/ready rx stream, writes weights and
// activations into tpu_top, starts a run and returns the four result words
// (LSB first) on an 8-bit valid/ready tx stream.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   rx_data/rx_valid/rx_ready       host -> loader byte stream
//   tx_data/tx_valid/tx_ready       loader -> host byte stream
//   load_weight/load_activation     single-cycle write strobes to tpu_top
//   load_addr/load_data             write address/data to tpu_top
//   start                           one-cycle run pulse to tpu_top
//   matrix_size                     active matrix dimension, held between runs
//   busy, done, result_0..3         status and results from tpu_top
//   err                             sticky errors: [0] opcode, [1] timeout, [2] size
module tpu_host_loader #(
  parameter int unsigned SIZE         = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH    = 32,
  parameter int unsigned DONE_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  load_weight,
  output logic                  load_activation,
  output logic [7:0]            load_addr,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  start,
  output logic [7:0]            matrix_size,
  input  logic                  busy,
  input  logic                  done,
  input  logic [ACC_WIDTH-1:0]  result_0,
  input  logic [ACC_WIDTH-1:0]  result_1,
  input  logic [ACC_WIDTH-1:0]  result_2,
  input  logic [ACC_WIDTH-1:0]  result_3,
  output logic [2:0]            err
);

  localparam int unsigned NBYTES = 4 * ACC_WIDTH / 8;
  localparam int unsigned BCNT_W = $clog2(NBYTES + 1);
  localparam int unsigned TO_W   = $clog2(DONE_TIMEOUT + 1);
  localparam int unsigned SH_W   = 4 * ACC_WIDTH;

  localparam logic [7:0] OP_W     = 8'h57;
  localparam logic [7:0] OP_A     = 8'h41;
  localparam logic [7:0] OP_S     = 8'h53;
  localparam logic [7:0] OP_C     = 8'h43;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_LEN, S_LOAD, S_GET_SIZE, S_START, S_WAIT_DONE, S_SEND
  } state_e;

  state_e                state_q, state_d;
  logic                  tgt_w_q, tgt_w_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            idx_q, idx_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  load_weight_q, load_weight_d;
  logic                  load_activation_q, load_activation_d;
  logic [7:0]            load_addr_q, load_addr_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  start_q, start_d;
  logic [7:0]            matrix_size_q, matrix_size_d;
  logic [2:0]            err_q, err_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [SH_W-1:0]       sh_q, sh_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [BCNT_W-1:0]     tx_cnt_q, tx_cnt_d;

  logic rx_fire;
  logic tx_fire;
  logic unused_busy;

  assign rx_fire     = rx_valid && rx_ready_q;
  assign tx_fire     = tx_valid_q && tx_ready;
  assign unused_busy = busy;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      tgt_w_q           <= 1'b0;
      len_q             <= '0;
      idx_q             <= '0;
      rx_ready_q        <= 1'b0;
      load_weight_q     <= 1'b0;
      load_activation_q <= 1'b0;
      load_addr_q       <= '0;
      load_data_q       <= '0;
      start_q           <= 1'b0;
      matrix_size_q     <= '0;
      err_q             <= '0;
      to_cnt_q          <= '0;
      sh_q              <= '0;
      tx_data_q         <= '0;
      tx_valid_q        <= 1'b0;
      tx_cnt_q          <= '0;
    end else begin
      state_q           <= state_d;
      tgt_w_q           <= tgt_w_d;
      len_q             <= len_d;
      idx_q             <= idx_d;
      rx_ready_q        <= rx_ready_d;
      load_weight_q     <= load_weight_d;
      load_activation_q <= load_activation_d;
      load_addr_q       <= load_addr_d;
      load_data_q       <= load_data_d;
      start_q           <= start_d;
      matrix_size_q     <= matrix_size_d;
      err_q             <= err_d;
      to_cnt_q          <= to_cnt_d;
      sh_q              <= sh_d;
      tx_data_q         <= tx_data_d;
      tx_valid_q        <= tx_valid_d;
      tx_cnt_q          <= tx_cnt_d;
    end
  end

  // Command parser, load sequencer, run control and tx serializer
  always_comb begin
    state_d           = state_q;
    tgt_w_d           = tgt_w_q;
    len_d             = len_q;
    idx_d             = idx_q;
    load_weight_d     = 1'b0;
    load_activation_d = 1'b0;
    load_addr_d       = load_addr_q;
    load_data_d       = load_data_q;
    start_d           = 1'b0;
    matrix_size_d     = matrix_size_q;
    err_d             = err_q;
    to_cnt_d          = to_cnt_q;
    sh_d              = sh_q;
    tx_data_d         = tx_data_q;
    tx_valid_d        = tx_valid_q;
    tx_cnt_d          = tx_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          unique case (rx_data)
            OP_W: begin
              tgt_w_d = 1'b1;
              state_d = S_GET_LEN;
            end
            OP_A: begin
              tgt_w_d = 1'b0;
              state_d = S_GET_LEN;
            end
            OP_S:    state_d  = S_GET_SIZE;
            OP_C:    err_d    = '0;
            default: err_d[0] = 1'b1;
          endcase
        end
      end

      S_GET_LEN: begin
        if (rx_fire) begin
          if (rx_data == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            len_d   = rx_data;
            idx_d   = '0;
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (rx_fire) begin
          load_weight_d     = tgt_w_q;
          load_activation_d = !tgt_w_q;
          load_addr_d       = idx_q;
          load_data_d       = DATA_WIDTH'(rx_data);
          idx_d             = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) begin
            state_d = S_IDLE;
          end
        end
      end

      S_GET_SIZE: begin
        if (rx_fire) begin
          if (rx_data == 8'd0 || rx_data > 8'(SIZE)) begin
            err_d[2]   = 1'b1;
            tx_data_d  = ERR_BYTE;
            tx_valid_d = 1'b1;
            tx_cnt_d   = BCNT_W'(1);
            state_d    = S_SEND;
          end else begin
            matrix_size_d = rx_data;
            start_d       = 1'b1;
            to_cnt_d      = '0;
            state_d       = S_START;
          end
        end
      end

      S_START: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_DONE;
      end

      // done wins over a timeout landing on the same cycle
      S_WAIT_DONE: begin
        if (done) begin
          sh_d       = SH_W'({result_3, result_2, result_1, result_0} >> 8);
          tx_data_d  = result_0[7:0];
          tx_valid_d = 1'b1;
          tx_cnt_d   = BCNT_W'(NBYTES);
          state_d    = S_SEND;
        end else if (to_cnt_q == TO_W'(DONE_TIMEOUT - 1)) begin
          err_d[1]   = 1'b1;
          tx_data_d  = ERR_BYTE;
          tx_valid_d = 1'b1;
          tx_cnt_d   = BCNT_W'(1);
          state_d    = S_SEND;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      // tx_data only advances on a handshake, so it is stable under stall
      S_SEND: begin
        if (tx_fire) begin
          if (tx_cnt_q == BCNT_W'(1)) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_data_d = sh_q[7:0];
            sh_d      = sh_q >> 8;
            tx_cnt_d  = tx_cnt_q - BCNT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // rx_ready registered from the state being entered
  always_comb begin
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_GET_LEN) ||
                 (state_d == S_LOAD) || (state_d == S_GET_SIZE);
  end

  assign rx_ready        = rx_ready_q;
  assign tx_data         = tx_data_q;
  assign tx_valid        = tx_valid_q;
  assign load_weight     = load_weight_q;
  assign load_activation = load_activation_q;
  assign load_addr       = load_addr_q;
  assign load_data       = load_data_q;
  assign start           = start_q;
  assign matrix_size     = matrix_size_q;
  assign err             = err_q;

endmodule

// File: tb/tb_tpu_host_loader.sv
// Directed bench for tpu_host_loader; tpu_top is stood in for by driving
// done/result_* directly from the stimulus sequence.
module tb_tpu_host_loader;

  localparam int unsigned DONE_TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        load_weight;
  logic        load_activation;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;
  logic        start;
  logic [7:0]  matrix_size;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic [31:0] result_0 = '0;
  logic [31:0] result_1 = '0;
  logic [31:0] result_2 = '0;
  logic [31:0] result_3 = '0;
  logic [2:0]  err;

  tpu_host_loader #(
    .SIZE(4), .DATA_WIDTH(8), .ACC_WIDTH(32), .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .load_weight(load_weight), .load_activation(load_activation),
    .load_addr(load_addr), .load_data(load_data),
    .start(start), .matrix_size(matrix_size),
    .busy(busy), .done(done),
    .result_0(result_0), .result_1(result_1),
    .result_2(result_2), .result_3(result_3),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_start  = 0;

  logic [1:0]  ld_kind[$];
  logic [7:0]  ld_addr[$];
  logic [7:0]  ld_data[$];
  int          ld_cyc[$];
  logic [7:0]  sq[$];
  logic [7:0]  rq[$];
  logic [31:0] res_w[4];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every load strobe and start pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (load_weight || load_activation) begin
      ld_kind.push_back({load_activation, load_weight});
      ld_addr.push_back(load_addr);
      ld_data.push_back(load_data);
      ld_cyc.push_back(cyc);
    end
    if (start) n_start = n_start + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_loads();
    ld_kind.delete(); ld_addr.delete(); ld_data.delete(); ld_cyc.delete();
  endtask

  // Present one byte from a falling edge; returns at the falling edge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int  t;
    logic ok;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      ok = rx_ready;
      @(negedge clk);
      if (ok) break;
      t++;
      if (t > 200) begin
        chk("rx_accept_timeout", 32'(t), 32'd0);
        break;
      end
    end
  endtask

  // Stream sq back-to-back with rx_valid held high
  task automatic send_seq();
    foreach (sq[i]) send_byte(sq[i]);
    rx_valid = 1'b0;
  endtask

  // Collect n tx bytes into rq; toggled ready exercises stall stability
  task automatic recv(input int n, input bit toggle, input int bound);
    int   t;
    bit   stalled;
    logic [7:0] held;
    t = 0;
    stalled = 1'b0;
    held = '0;
    rq.delete();
    while (rq.size() < n && t < bound) begin
      tx_ready = toggle ? ~tx_ready : 1'b1;
      if (stalled) begin
        chk("tx_stall_valid", 32'(tx_valid), 32'd1);
        chk("tx_stall_data", 32'(tx_data), 32'(held));
      end
      stalled = tx_valid && !tx_ready;
      held    = tx_data;
      if (tx_valid && tx_ready) rq.push_back(tx_data);
      @(negedge clk);
      t++;
    end
    tx_ready = 1'b0;
    chk("tx_byte_count", 32'(rq.size()), 32'(n));
    chk("tx_valid_after_last", 32'(tx_valid), 32'd0);
  endtask

  task automatic check_result_bytes(input string tag);
    for (int i = 0; i < 16; i++) begin
      if (i < rq.size())
        chk(tag, 32'(rq[i]), 32'(res_w[i / 4][8 * (i % 4) +: 8]));
    end
  endtask

  task automatic pulse_done();
    result_0 = res_w[0]; result_1 = res_w[1];
    result_2 = res_w[2]; result_3 = res_w[3];
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_load_w"}, 32'(load_weight), 32'd0);
    chk({tag, "_load_a"}, 32'(load_activation), 32'd0);
    chk({tag, "_load_addr"}, 32'(load_addr), 32'd0);
    chk({tag, "_load_data"}, 32'(load_data), 32'd0);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_msize"}, 32'(matrix_size), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic check_single_w9();
    repeat (2) @(negedge clk);
    chk("w9_count", 32'(ld_kind.size()), 32'd1);
    if (ld_kind.size() == 1) begin
      chk("w9_kind", 32'(ld_kind[0]), 32'd1);
      chk("w9_addr", 32'(ld_addr[0]), 32'd0);
      chk("w9_data", 32'(ld_data[0]), 32'd9);
    end
  endtask

  initial begin
    int s0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rx_ready", 32'(rx_ready), 32'd1);

    // Back-to-back weight and activation loads
    sq = '{8'h57, 8'h04, 8'h05, 8'h07, 8'h06, 8'h08,
           8'h41, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    send_seq();
    repeat (2) @(negedge clk);
    chk("load_count", 32'(ld_kind.size()), 32'd8);
    if (ld_kind.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        chk("w_kind", 32'(ld_kind[i]), 32'd1);
        chk("w_addr", 32'(ld_addr[i]), 32'(i));
        chk("w_gapless", 32'(ld_cyc[i]), 32'(ld_cyc[0] + i));
        chk("a_kind", 32'(ld_kind[4 + i]), 32'd2);
        chk("a_addr", 32'(ld_addr[4 + i]), 32'(i));
        chk("a_data", 32'(ld_data[4 + i]), 32'(i + 1));
        chk("a_gapless", 32'(ld_cyc[4 + i]), 32'(ld_cyc[4] + i));
      end
      chk("w_data0", 32'(ld_data[0]), 32'd5);
      chk("w_data1", 32'(ld_data[1]), 32'd7);
      chk("w_data2", 32'(ld_data[2]), 32'd6);
      chk("w_data3", 32'(ld_data[3]), 32'd8);
    end
    chk("loads_no_err", 32'(err), 32'd0);

    // Run with size 2, results 19,22,43,50
    s0 = n_start;
    sq = '{8'h53, 8'h02};
    send_seq();
    chk("start_pulse", 32'(start), 32'd1);
    chk("msize_2", 32'(matrix_size), 32'd2);
    chk("rx_ready_in_run", 32'(rx_ready), 32'd0);
    @(negedge clk);
    chk("start_single", 32'(start), 32'd0);
    repeat (2) @(negedge clk);
    chk("rx_ready_wait", 32'(rx_ready), 32'd0);
    res_w = '{32'd19, 32'd22, 32'd43, 32'd50};
    pulse_done();
    recv(16, 1'b0, 100);
    check_result_bytes("run1_byte");
    chk("run1_starts", 32'(n_start - s0), 32'd1);
    chk("run1_rx_ready", 32'(rx_ready), 32'd1);
    chk("run1_msize_held", 32'(matrix_size), 32'd2);

    // Identity run with a stalling host
    clear_loads();
    sq = '{8'h57, 8'h04, 8'h01, 8'h00, 8'h00, 8'h01,
           8'h41, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h53, 8'h02};
    send_seq();
    repeat (3) @(negedge clk);
    res_w = '{32'd5, 32'd6, 32'd7, 32'd8};
    pulse_done();
    recv(16, 1'b1, 200);
    check_result_bytes("ident_byte");

    // Bad opcode, bad size, clear
    clear_loads();
    s0 = n_start;
    send_byte(8'h99);
    rx_valid = 1'b0;
    chk("err_opcode", 32'(err), 32'd1);
    sq = '{8'h53, 8'h00};
    send_seq();
    chk("err_size", 32'(err), 32'd5);
    recv(1, 1'b0, 20);
    if (rq.size() == 1) chk("size_err_byte", 32'(rq[0]), 32'hEE);
    chk("no_loads_on_err", 32'(ld_kind.size()), 32'd0);
    chk("no_start_on_err", 32'(n_start - s0), 32'd0);
    sq = '{8'h53, 8'h05};
    send_seq();
    recv(1, 1'b0, 20);
    if (rq.size() == 1) chk("size5_err_byte", 32'(rq[0]), 32'hEE);
    send_byte(8'h43);
    rx_valid = 1'b0;
    chk("err_clear", 32'(err), 32'd0);

    // done never arrives
    sq = '{8'h53, 8'h02};
    send_seq();
    recv(1, 1'b0, DONE_TIMEOUT + 50);
    if (rq.size() == 1) chk("timeout_byte", 32'(rq[0]), 32'hEE);
    chk("err_timeout", 32'(err), 32'd2);
    clear_loads();
    sq = '{8'h57, 8'h01, 8'h09};
    send_seq();
    check_single_w9();
    send_byte(8'h43);
    rx_valid = 1'b0;

    // Reset in the middle of a load
    clear_loads();
    sq = '{8'h57, 8'h04, 8'h11, 8'h22};
    send_seq();
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_load");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_load_partial", 32'(ld_kind.size()), 32'd2);
    clear_loads();
    sq = '{8'h57, 8'h01, 8'h09};
    send_seq();
    check_single_w9();

    // Reset in the middle of a send
    sq = '{8'h53, 8'h01};
    send_seq();
    repeat (3) @(negedge clk);
    res_w = '{32'hAABBCCDD, 32'd1, 32'd2, 32'd3};
    pulse_done();
    chk("send_valid", 32'(tx_valid), 32'd1);
    chk("send_first", 32'(tx_data), 32'hDD);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_send");
    @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_send_quiet", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    clear_loads();
    sq = '{8'h57, 8'h01, 8'h09};
    send_seq();
    check_single_w9();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
